sfu_reduce: RTL and testbench

//  Streaming reduction stage directly downstream of the SFU. Consumes the SFU's signed
//  int8 result stream one element per beat. On the last beat of a vector it emits that

---
 rtl/sfu_pkg.sv | 13 +
 rtl/sfu_reduce_if.sv | 29 ++
 rtl/sfu_sat_add.sv | 22 ++
 rtl/sfu_reduce.sv | 89 ++++++++
 tb/tb_sfu_reduce.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU reduction stage: FSM encodings and int8 limits.
package sfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic signed [7:0] INT8_MIN = -8'sd128;
    localparam logic signed [7:0] INT8_MAX = 8'sd127;

endpackage

// File: rtl/sfu_reduce_if.sv
// Element stream in, result word out. Both sides use valid/ready: a transfer happens on a
// rising edge where valid and ready are both high; valid, once raised, holds its payload steady.
interface sfu_reduce_if #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic signed [7:0]       in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic                    abort;
    logic signed [ACC_W-1:0] out_sum;
    logic signed [7:0]       out_max;
    logic signed [7:0]       out_min;
    logic [CNT_W-1:0]        out_count;
    logic                    out_ovf;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, in_last, abort, out_ready,
        input  in_ready, out_sum, out_max, out_min, out_count, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, abort, out_ready,
        output in_ready, out_sum, out_max, out_min, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/sfu_sat_add.sv
// Combinational signed accumulator + sign-extended int8 add, clamped to the accumulator range.
module sfu_sat_add #(
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [7:0]       x,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sat
);
    logic signed [ACC_W:0] wide;

    always_comb begin
        wide = {acc[ACC_W-1], acc} + {{(ACC_W-7){x[7]}}, x};
        sum  = wide[ACC_W-1:0];
        sat  = 1'b0;
        // Top two bits disagree only when the true result left the ACC_W range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat = 1'b1;
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/sfu_reduce.sv
// Streaming per-vector sum/max/min/count reduction of the SFU int8 output stream.
module sfu_reduce
    import sfu_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    sfu_reduce_if.slave  bus,
    output state_t       dbg_state
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [7:0]       max_q, min_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic                    accept;
    logic signed [ACC_W-1:0] sum_next;
    logic                    sum_sat;
    logic                    cnt_full;

    // abort outranks in_valid, so an aborted beat is never accepted.
    assign accept   = bus.in_valid && (state_q != ST_HOLD) && !bus.abort;
    assign cnt_full = (cnt_q == CNT_MAX);

    sfu_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .acc (sum_q),
        .x   (bus.in_data),
        .sum (sum_next),
        .sat (sum_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (bus.abort)   state_d = ST_IDLE;
                else if (accept) state_d = bus.in_last ? ST_HOLD : ST_ACCUM;
            end
            ST_HOLD: begin
                // abort is deliberately ignored here: a finished result is always delivered.
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            max_q <= '0;
            min_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                sum_q <= {{(ACC_W-8){bus.in_data[7]}}, bus.in_data};
                max_q <= bus.in_data;
                min_q <= bus.in_data;
                cnt_q <= CNT_W'(1);
                ovf_q <= 1'b0;
            end else begin
                sum_q <= sum_next;
                if (bus.in_data > max_q) max_q <= bus.in_data;
                if (bus.in_data < min_q) min_q <= bus.in_data;
                // Count sticks at its maximum; an uncountable element flags overflow.
                if (!cnt_full) cnt_q <= cnt_q + CNT_W'(1);
                ovf_q <= ovf_q | sum_sat | cnt_full;
            end
        end
    end

    assign bus.in_ready  = (state_q != ST_HOLD);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_max   = max_q;
    assign bus.out_min   = min_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_sfu_reduce.sv
// Randomized self-checking bench for sfu_reduce against a vector-level reference model.
module tb_sfu_reduce;
    import sfu_pkg::*;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam int RW    = ACC_W + 16 + CNT_W + 1;
    localparam longint SUM_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint SUM_MIN = -(longint'(1) <<< (ACC_W-1));
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_errors = 0;
    int     vec_q[$];
    logic [RW-1:0] exp_q[$];

    sfu_reduce_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    sfu_reduce #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] observed();
        return {bus.out_sum, bus.out_max, bus.out_min, bus.out_count, bus.out_ovf};
    endfunction

    // Reference: step through the vector with unbounded arithmetic, clamping each partial sum.
    function automatic logic [RW-1:0] model();
        longint s = 0;
        int mx = 0, mn = 0, n = 0;
        bit ovf = 1'b0;
        for (int i = 0; i < vec_q.size(); i++) begin
            int x = vec_q[i];
            if (i == 0) begin
                s = x; mx = x; mn = x; n = 1;
            end else begin
                s = s + x;
                if (s > SUM_MAX) begin s = SUM_MAX; ovf = 1'b1; end
                if (s < SUM_MIN) begin s = SUM_MIN; ovf = 1'b1; end
                if (x > mx) mx = x;
                if (x < mn) mn = x;
                if (n == CNT_MAX) ovf = 1'b1;
                else n++;
            end
        end
        return {ACC_W'(s), 8'(mx), 8'(mn), CNT_W'(n), ovf};
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic drive_beat(input int x, input bit last);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_wait: in_ready=%0b after %0d cycles, required 1", bus.in_ready, t);
        end
        bus.in_data  = 8'(x);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_vec();
        exp_q.push_back(model());
        for (int i = 0; i < vec_q.size(); i++)
            drive_beat(vec_q[i], i == vec_q.size() - 1);
    endtask

    task automatic check_result(input string name, output logic [RW-1:0] expw);
        int t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        expw = exp_q.pop_front();
        n_checks++;
        if (!bus.out_valid) begin
            n_errors++;
            $display("FAIL %s_valid: out_valid=%0b, required 1", name, bus.out_valid);
        end else if (observed() !== expw) begin
            n_errors++;
            $display("FAIL %s: got sum/max/min/cnt/ovf=%h, required %h", name, observed(), expw);
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL %s: out_valid=%0b in_ready=%0b state=%0d, required 0/1/%0d",
                     name, bus.out_valid, bus.in_ready, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_flags");
        n_checks++;
        if (observed() !== '0) begin
            n_errors++;
            $display("FAIL reset_fields: got %h, required 0", observed());
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_basic();
        logic [RW-1:0] e;
        bus.out_ready = 1'b1;
        vec_q = '{3, -5, 10, 1};
        send_vec();
        check_result("basic", e);
        n_checks++;
        if (e !== {16'sd9, 8'sd10, -8'sd5, 8'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL basic_model: model %h, required sum=9 max=10 min=-5 cnt=4", e);
        end
        @(negedge clk);
        check_idle("basic_one_cycle");
    endtask

    task automatic test_single();
        logic [RW-1:0] e;
        vec_q = '{-7};
        send_vec();
        check_result("single", e);
        @(negedge clk);
        check_idle("single_done");
    endtask

    task automatic test_saturation();
        logic [RW-1:0] e;
        vec_q = {};
        for (int i = 0; i < 300; i++) vec_q.push_back(127);
        send_vec();
        check_result("sat_pos", e);
        n_checks++;
        if (e !== {16'sd32767, 8'sd127, 8'sd127, 8'd255, 1'b1}) begin
            n_errors++;
            $display("FAIL sat_pos_model: model %h", e);
        end
        @(negedge clk);
        vec_q = {};
        for (int i = 0; i < 300; i++) vec_q.push_back(int'(INT8_MIN));
        send_vec();
        check_result("sat_neg", e);
        @(negedge clk);
        check_idle("sat_done");
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] e;
        bus.out_ready = 1'b0;
        vec_q = '{20, -30, 40};
        send_vec();
        check_result("bp_first", e);
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 8'($urandom_range(0, 255));
            bus.in_last  = 1'b1;
            bus.in_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observed() !== e) begin
                n_errors++;
                $display("FAIL bp_hold: valid=%0b ready=%0b word=%h, required 1/0/%h",
                         bus.out_valid, bus.in_ready, observed(), e);
            end
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_idle("bp_release");
        vec_q = '{4, 5};
        send_vec();
        check_result("bp_next", e);
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [RW-1:0] e;
        drive_beat(50, 1'b0);
        drive_beat(60, 1'b0);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = 8'sd99;
        @(negedge clk);
        check_idle("abort_accum");
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        vec_q = '{1, 2};
        send_vec();
        check_result("abort_next", e);
        @(negedge clk);
        bus.out_ready = 1'b0;
        vec_q = '{7, -3};
        send_vec();
        check_result("abort_hold_res", e);
        bus.abort = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || dbg_state !== ST_HOLD || observed() !== e) begin
            n_errors++;
            $display("FAIL abort_hold: valid=%0b state=%0d word=%h, required 1/%0d/%h",
                     bus.out_valid, dbg_state, observed(), ST_HOLD, e);
        end
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_idle("abort_hold_done");
    endtask

    task automatic test_reset_mid();
        drive_beat(5, 1'b0);
        drive_beat(6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid_flags");
        n_checks++;
        if (observed() !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_fields: got %h, required 0", observed());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [RW-1:0] e;
        for (int v = 0; v < 25; v++) begin
            int len = $urandom_range(1, 24);
            vec_q = {};
            for (int i = 0; i < len; i++)
                vec_q.push_back(int'($urandom_range(0, 255)) + int'(INT8_MIN));
            bus.out_ready = 1'b0;
            send_vec();
            check_result("random", e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            check_idle("random_done");
        end
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_single();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
